queue_arbiter: RTL and testbench
================================

# queue_arbiter

Two-producer, one-consumer queue controller. It owns an 8-entry circular register buffer with head/tail counters and shares its single write port between two requesters by round-robin arbitration. It serves pops from the consumer with a one-cycle registered read. It sits between the input switches/debouncers and the seven-segment display path, replacing single-writer queue sequencing.

## Interface
- `DW`, 4, data word width
- `AW`, 3, address width; depth = 2^AW = 8 entries, all usable
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `push_req0`  in  1  requester 0 wants to write `push_data0`
- `push_data0`  in  DW  requester 0 write data
- `push_gnt0`  out  1  requester 0 write accepted this cycle (combinational)
- `push_req1`  in  1  requester 1 wants to write `push_data1`
- `push_data1`  in  DW  requester 1 write data
- `push_gnt1`  out  1  requester 1 write accepted this cycle (combinational)
- `pop_req`  in  1  consumer requests one word
- `pop_valid`  out  1  registered; `pop_data` holds a popped word this cycle
- `pop_data`  out  DW  registered popped word; holds its last value when `pop_valid`=0
- `full`  out  1  count == 8
- `empty`  out  1  count == 0
- `count`  out  AW+1  occupancy 0..8
- `prio`  out  1  requester favoured on the next conflict

## Operation
- State: `mem[0..7]`, `head`[AW], `tail`[AW], `count`[AW+1], `prio`, `pop_valid`, `pop_data`.
- Pointers wrap modulo 8 by natural AW-bit overflow. `full` and `empty` come from `count` only, never from pointer comparison.
- Arbitration is combinational from registered state:
  - `can_push = ~full`.
  - Only req0: `gnt0 = can_push`. Only req1: `gnt1 = can_push`.
  - Both requesting: grant goes to `prio` (0 → gnt0, 1 → gnt1), if `can_push`.
  - At most one grant per cycle. Grants are 0 while `rst`=0.
- On an edge with a grant:
  - `mem[tail] <= granted data`, `tail <= tail+1`.
  - `prio <= ~granted index`, so the loser of a conflict wins next time.
  - `prio` changes only on a grant.
- Pop is accepted when `pop_req & ~empty`. At the edge: `pop_data <= mem[head]`, `head <= head+1`, `pop_valid <= 1`.
- Pop when empty: ignored, `pop_valid <= 0`, `pop_data` unchanged, no error state.
- Count update per edge: +1 for push only, −1 for pop only, unchanged for both.
- Full and pop in the same cycle: the pop proceeds; the push is still refused, because `full` is registered. A write is allowed again on the next cycle.
- Empty and push in the same cycle: the push proceeds; the pop is refused. The new word is poppable from the next cycle.
- Push and pop at the same address cannot happen: this would require count 0 (pop refused) or count 8 (push refused).

## Timing
- Async reset (rst=0), applied immediately regardless of clock:
  - head=tail=0, count=0, all mem=0, prio=0.
  - pop_valid=0, pop_data=0, empty=1, full=0, gnt0=gnt1=0.
- Reset asserted mid-operation discards all contents. The first edge after release behaves as from a fresh reset.
- Push latency: the grant is visible in the same cycle as the request. Data is stored at that edge. `count`, `empty` and `full` update one edge later, on the same edge as the write.
- Pop latency: `pop_req` sampled at edge N gives `pop_valid`=1 with the data after edge N, for exactly one cycle per accepted pop.
- Back-to-back pops on consecutive cycles deliver consecutive words with `pop_valid` held high.
- Requesters hold `req`/`data` until they see `gnt`. A request deasserted without a grant is simply dropped.

## Test plan
- Reset, then req0 pushes 0x3, 0x5, 0x7 on three consecutive cycles → gnt0=1 each cycle, count=3, tail=3, empty=0. Three pops → pop_data 0x3, 0x5, 0x7, each with pop_valid=1 on the cycle after its pop_req; then empty=1.
- req0 (0xA) and req1 (0xB) held together for 4 cycles from reset → grants alternate 0,1,0,1. Pops return A, B, A, B. prio=0 at the end.
- Fill to 8 with 0x0..0x7 → full=1. A further req1 (0xF) gets gnt1=0. Pop plus req1 in the same cycle → pop_data=0x0, gnt1=0 that cycle, gnt1=1 the next cycle, count returns to 8. The last pop after draining yields 0xF (wrap-around, tail passes 7→0).
- From empty, pop_req alone → pop_valid=0 and count stays 0. Push 0x9 with pop_req in the same cycle → pop refused. Pop on the next cycle → 0x9.
- With count=4, continuous push (req0) plus pop for 10 cycles → count stays 4, FIFO order preserved across the pointer wrap.
- Pull rst low mid-stream with count=5 and pop_valid=1 → all outputs go to reset values with no clock edge. After release, a push of 0x2 and a pop return 0x2.

Source files
------------

// File: rtl/queue_arbiter.sv
// Eight-entry circular queue whose single write port is shared by two
// requesters under round-robin arbitration, with a registered pop port.
module queue_arbiter #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req0,
    input  logic [DW-1:0] push_data0,
    output logic          push_gnt0,
    input  logic          push_req1,
    input  logic [DW-1:0] push_data1,
    output logic          push_gnt1,
    input  logic          pop_req,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          prio
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push_en;
    logic          pop_en;
    logic [DW-1:0] push_word;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // Handshake: a requester holds req/data until it sees its gnt in the same
    // cycle; the write happens on that edge. A pop with pop_req & ~empty is
    // accepted on the edge and pop_valid/pop_data follow for one cycle.
    always_comb begin
        push_gnt0 = 1'b0;
        push_gnt1 = 1'b0;
        if (rst && !full) begin
            if (push_req0 && push_req1) begin
                if (prio) push_gnt1 = 1'b1;
                else      push_gnt0 = 1'b1;
            end else if (push_req0) begin
                push_gnt0 = 1'b1;
            end else if (push_req1) begin
                push_gnt1 = 1'b1;
            end
        end
    end

    assign push_en   = push_gnt0 | push_gnt1;
    assign push_word = push_gnt1 ? push_data1 : push_data0;
    assign pop_en    = pop_req & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            prio      <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_en) begin
                mem[tail] <= push_word;
                tail      <= tail + PTR_ONE;
                // The loser of this grant is favoured next time.
                prio      <= push_gnt0;
            end
            pop_valid <= pop_en;
            if (pop_en) begin
                pop_data <= mem[head];
                head     <= head + PTR_ONE;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: a reference model tracks occupancy and an
// expected-data queue supplies the word every accepted pop must return.
module tb_queue_arbiter;

    logic       clk;
    logic       rst;
    logic       push_req0;
    logic [3:0] push_data0;
    logic       push_gnt0;
    logic       push_req1;
    logic [3:0] push_data1;
    logic       push_gnt1;
    logic       pop_req;
    logic       pop_valid;
    logic [3:0] pop_data;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       prio;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_count = 0;
    logic [3:0] last_data = '0;
    logic [3:0] exp_q[$];

    queue_arbiter #(.DW(4), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .push_req0(push_req0), .push_data0(push_data0), .push_gnt0(push_gnt0),
        .push_req1(push_req1), .push_data1(push_data1), .push_gnt1(push_gnt1),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
        .full(full), .empty(empty), .count(count), .prio(prio)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; asserts reset, checks it took effect with no
    // clock edge, and releases it before the next edge.
    task automatic apply_reset(input string tag);
        push_req0 = 1'b1; push_req1 = 1'b1; pop_req = 1'b1;
        push_data0 = 4'hC; push_data1 = 4'hD;
        rst = 1'b0;
        #1;
        check({tag, "_gnt0"},      push_gnt0, 1'b0);
        check({tag, "_gnt1"},      push_gnt1, 1'b0);
        check({tag, "_pop_valid"}, pop_valid, 1'b0);
        check({tag, "_pop_data"},  pop_data,  4'h0);
        check({tag, "_count"},     count,     4'd0);
        check({tag, "_empty"},     empty,     1'b1);
        check({tag, "_full"},      full,      1'b0);
        check({tag, "_prio"},      prio,      1'b0);
        push_req0 = 1'b0; push_req1 = 1'b0; pop_req = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_count   = 0;
        last_data = '0;
    endtask

    // driver: one clock cycle of stimulus with expected grants
    task automatic do_cycle(input logic r0, input logic [3:0] d0,
                            input logic r1, input logic [3:0] d1,
                            input logic pop, input logic eg0, input logic eg1);
        logic       exp_pop;
        logic [3:0] exp_word;
        push_req0 = r0; push_data0 = d0;
        push_req1 = r1; push_data1 = d1;
        pop_req   = pop;
        #1;
        check("gnt0", push_gnt0, eg0);
        check("gnt1", push_gnt1, eg1);
        if (eg0) exp_q.push_back(d0);
        if (eg1) exp_q.push_back(d1);
        exp_pop = pop && (m_count != 0);
        @(posedge clk);
        #1;
        m_count = m_count + int'(eg0) + int'(eg1) - int'(exp_pop);
        check("pop_valid", pop_valid, exp_pop);
        if (exp_pop) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL scoreboard_underflow: observed 0 entries expected >0");
            end else begin
                exp_word = exp_q.pop_front();
                check("pop_data", pop_data, exp_word);
                last_data = exp_word;
            end
        end else begin
            check("pop_data_hold", pop_data, last_data);
        end
        check("count", count, m_count[3:0]);
        check("empty", empty, m_count == 0);
        check("full",  full,  m_count == 8);
    endtask

    task automatic idle();
        push_req0 = 1'b0; push_req1 = 1'b0; pop_req = 1'b0;
    endtask

    initial begin
        logic [3:0] d;
        rst = 1'b0;
        idle();
        push_data0 = '0; push_data1 = '0;
        @(posedge clk);
        #1;
        apply_reset("reset0");

        // three pushes from requester 0, then three pops
        do_cycle(1, 4'h3, 0, 4'h0, 0, 1, 0);
        do_cycle(1, 4'h5, 0, 4'h0, 0, 1, 0);
        do_cycle(1, 4'h7, 0, 4'h0, 0, 1, 0);
        check("t1_count3", count, 4'd3);
        repeat (3) do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        do_cycle(0, 4'h0, 0, 4'h0, 0, 0, 0);
        check("t1_empty", empty, 1'b1);

        // conflicting requesters alternate from a fresh reset
        apply_reset("reset1");
        do_cycle(1, 4'hA, 1, 4'hB, 0, 1, 0);
        check("t2_prio_after0", prio, 1'b1);
        do_cycle(1, 4'hA, 1, 4'hB, 0, 0, 1);
        check("t2_prio_after1", prio, 1'b0);
        do_cycle(1, 4'hA, 1, 4'hB, 0, 1, 0);
        do_cycle(1, 4'hA, 1, 4'hB, 0, 0, 1);
        check("t2_prio_end", prio, 1'b0);
        repeat (4) do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);

        // fill, refuse when full, pop frees a slot one cycle later, wrap
        for (int i = 0; i < 8; i++) do_cycle(1, 4'(i), 0, 4'h0, 0, 1, 0);
        check("t3_full", full, 1'b1);
        do_cycle(0, 4'h0, 1, 4'hF, 0, 0, 0);
        do_cycle(0, 4'h0, 1, 4'hF, 1, 0, 0);
        check("t3_pop_first", pop_data, 4'h0);
        do_cycle(0, 4'h0, 1, 4'hF, 0, 0, 1);
        check("t3_refill", count, 4'd8);
        repeat (8) do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        check("t3_wrap_last", pop_data, 4'hF);

        // pop on empty is ignored; push and pop together on empty
        do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        do_cycle(1, 4'h9, 0, 4'h0, 1, 1, 0);
        do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        check("t4_pop9", pop_data, 4'h9);

        // steady state at count 4 with simultaneous push and pop
        for (int i = 0; i < 4; i++) do_cycle(1, 4'($urandom_range(0, 15)), 0, 4'h0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            d = 4'($urandom_range(0, 15));
            do_cycle(1, d, 0, 4'h0, 1, 1, 0);
            check("t5_count_steady", count, 4'd4);
        end
        repeat (4) do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) do_cycle(1, 4'(i + 8), 0, 4'h0, 0, 1, 0);
        do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        check("t6_pre_count", count, 4'd5);
        check("t6_pre_valid", pop_valid, 1'b1);
        apply_reset("reset_mid");
        idle();
        do_cycle(1, 4'h2, 0, 4'h0, 0, 1, 0);
        do_cycle(0, 4'h0, 0, 4'h0, 1, 0, 0);
        check("t6_pop2", pop_data, 4'h2);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
